// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64 base core: sequences fetch/decode/exec/mem/wb
// for R-type, load, store and branch, with sticky illegal-opcode and memory-timeout flags.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    C_R      = 2'd0,
    C_LOAD   = 2'd1,
    C_STORE  = 2'd2,
    C_BRANCH = 2'd3
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Index of the last tolerated request cycle; unused when WAIT_MAX is 0.
  localparam logic [7:0] WAIT_LAST = 8'((WAIT_MAX == 0) ? 0 : (WAIT_MAX - 1));
  localparam bit         WAIT_EN   = (WAIT_MAX != 0);

  state_t      cur_state, nxt_state;
  class_t      cls, dec_cls;
  logic        dec_ok;
  logic [7:0]  wait_cnt;
  logic        illegal_q, timeout_q;
  logic        req_state, ready, timeout_evt, taken;
  logic        instr_unused;

  assign instr_unused = ^instr[31:15];

  assign req_state   = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign ready       = (cur_state == S_FETCH) ? imem_ready : dmem_ready;
  assign timeout_evt = req_state && !ready && WAIT_EN && (wait_cnt == WAIT_LAST);
  assign taken       = instr[12] ? !zero : zero;

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    case (instr[6:0])
      OP_R:      dec_cls = C_R;
      OP_LOAD:   dec_cls = C_LOAD;
      OP_STORE:  dec_cls = C_STORE;
      OP_BRANCH: begin
        dec_cls = C_BRANCH;
        dec_ok  = (instr[14:13] == 2'b00);
      end
      default:   dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout_evt) begin
          nxt_state = S_HALT;
        end
      end
      S_DECODE: nxt_state = dec_ok ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (cls)
          C_R: begin
            alu_op    = 2'b10;
            nxt_state = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src_b = 1'b1;
            nxt_state = S_MEM;
          end
          default: begin
            alu_op    = 2'b01;
            pc_we     = 1'b1;
            pc_src    = taken;
            nxt_state = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (timeout_evt) begin
          nxt_state = S_HALT;
        end
      end
      S_WB: begin
        reg_we    = (instr[11:7] != 5'd0);
        wb_sel    = (cls == C_LOAD);
        pc_we     = 1'b1;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_HALT;
    endcase
  end

  // Wait counter restarts on any state change and saturates so a disabled timeout never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      cls       <= C_R;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) begin
        cls <= dec_cls;
        if (!dec_ok) illegal_q <= 1'b1;
      end
      if (timeout_evt) timeout_q <= 1'b1;
      if (nxt_state != cur_state)
        wait_cnt <= 8'd0;
      else if (req_state && !ready && (wait_cnt != 8'hFF))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign state   = cur_state;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with hand-computed expected strobes.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we, wb_sel;
  logic [2:0]  state;
  logic        illegal, timeout;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
    .illegal(illegal), .timeout(timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change one time unit after the edge; outputs are sampled one unit later.
  task automatic applyStimulus(input logic [31:0] i, input logic imr, input logic dmr, input logic z);
    instr = i; imem_ready = imr; dmem_ready = dmr; zero = z;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    rst_n = 1'b1;
  endtask

  task automatic fetchDecode(input string tag, input logic [31:0] i);
    applyStimulus(i, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, " fetch state"}, {29'd0, state}, 0);
    checkOutput({tag, " fetch ir_we"}, {31'd0, ir_we}, 1);
    checkOutput({tag, " fetch imem_req"}, {31'd0, imem_req}, 1);
    nextCycle();
    applyStimulus(i, 1'b1, 1'b1, 1'b0);
    checkOutput({tag, " decode state"}, {29'd0, state}, 1);
    checkOutput({tag, " decode ir_we"}, {31'd0, ir_we}, 0);
    nextCycle();
  endtask

  task automatic runBranch(input string tag, input logic [31:0] i, input logic z, input logic expSrc);
    fetchDecode(tag, i);
    applyStimulus(i, 1'b0, 1'b0, z);
    checkOutput({tag, " exec state"}, {29'd0, state}, 2);
    checkOutput({tag, " exec alu_op"}, {30'd0, alu_op}, 1);
    checkOutput({tag, " exec pc_we"}, {31'd0, pc_we}, 1);
    checkOutput({tag, " exec pc_src"}, {31'd0, pc_src}, {31'd0, expSrc});
    nextCycle();
    checkOutput({tag, " back to fetch"}, {29'd0, state}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    checkOutput("reset state", {29'd0, state}, 0);
    checkOutput("reset illegal", {31'd0, illegal}, 0);
    checkOutput("reset timeout", {31'd0, timeout}, 0);
    checkOutput("reset imem_req", {31'd0, imem_req}, 1);
    rst_n = 1'b1;

    // R-type add x3,x1,x2
    fetchDecode("add", 32'h002081B3);
    applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0);
    checkOutput("add exec state", {29'd0, state}, 2);
    checkOutput("add exec alu_op", {30'd0, alu_op}, 2);
    checkOutput("add exec alu_src_b", {31'd0, alu_src_b}, 0);
    nextCycle();
    checkOutput("add wb state", {29'd0, state}, 4);
    checkOutput("add wb reg_we", {31'd0, reg_we}, 1);
    checkOutput("add wb wb_sel", {31'd0, wb_sel}, 0);
    checkOutput("add wb pc_we", {31'd0, pc_we}, 1);
    nextCycle();
    checkOutput("add back to fetch", {29'd0, state}, 0);

    // Load with three wait cycles on data memory
    fetchDecode("ld", 32'h0080B183);
    applyStimulus(32'h0080B183, 1'b0, 1'b0, 1'b0);
    checkOutput("ld exec alu_src_b", {31'd0, alu_src_b}, 1);
    checkOutput("ld exec alu_op", {30'd0, alu_op}, 0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h0080B183, 1'b0, (k == 3), 1'b0);
      checkOutput($sformatf("ld mem%0d state", k), {29'd0, state}, 3);
      checkOutput($sformatf("ld mem%0d dmem_req", k), {31'd0, dmem_req}, 1);
      checkOutput($sformatf("ld mem%0d dmem_we", k), {31'd0, dmem_we}, 0);
      nextCycle();
    end
    applyStimulus(32'h0080B183, 1'b0, 1'b0, 1'b0);
    checkOutput("ld wb state", {29'd0, state}, 4);
    checkOutput("ld wb reg_we", {31'd0, reg_we}, 1);
    checkOutput("ld wb wb_sel", {31'd0, wb_sel}, 1);
    checkOutput("ld timeout", {31'd0, timeout}, 0);
    nextCycle();

    // Branches
    runBranch("beq taken", 32'h00208463, 1'b1, 1'b1);
    runBranch("beq not taken", 32'h00208463, 1'b0, 1'b0);
    runBranch("bne taken", 32'h00209463, 1'b0, 1'b1);
    runBranch("bne not taken", 32'h00209463, 1'b1, 1'b0);

    // R-type with rd=x0 writes nothing back
    fetchDecode("add x0", 32'h00208033);
    applyStimulus(32'h00208033, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("add x0 wb state", {29'd0, state}, 4);
    checkOutput("add x0 wb reg_we", {31'd0, reg_we}, 0);
    checkOutput("add x0 wb pc_we", {31'd0, pc_we}, 1);
    nextCycle();

    // Store with immediate ready
    fetchDecode("sd", 32'h0020B023);
    applyStimulus(32'h0020B023, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(32'h0020B023, 1'b0, 1'b1, 1'b0);
    checkOutput("sd mem dmem_we", {31'd0, dmem_we}, 1);
    checkOutput("sd mem pc_we", {31'd0, pc_we}, 1);
    checkOutput("sd mem pc_src", {31'd0, pc_src}, 0);
    nextCycle();
    checkOutput("sd back to fetch", {29'd0, state}, 0);

    // Reset during MEM of a store
    fetchDecode("sd rst", 32'h0020B023);
    applyStimulus(32'h0020B023, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(32'h0020B023, 1'b0, 1'b0, 1'b0);
    checkOutput("sd rst mem dmem_req", {31'd0, dmem_req}, 1);
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    checkOutput("sd rst state", {29'd0, state}, 0);
    checkOutput("sd rst dmem_req", {31'd0, dmem_req}, 0);

    // Unsupported opcode halts until reset
    fetchDecode("illop", 32'h0000007F);
    applyStimulus(32'h0000007F, 1'b1, 1'b1, 1'b0);
    checkOutput("illop state", {29'd0, state}, 5);
    checkOutput("illop illegal", {31'd0, illegal}, 1);
    nextCycle();
    nextCycle();
    checkOutput("illop held state", {29'd0, state}, 5);
    checkOutput("illop no imem_req", {31'd0, imem_req}, 0);
    checkOutput("illop no ir_we", {31'd0, ir_we}, 0);
    doReset();
    checkOutput("illop reset state", {29'd0, state}, 0);
    checkOutput("illop reset illegal", {31'd0, illegal}, 0);

    // Branch with funct3=010 is illegal
    fetchDecode("illbr", 32'h0020A463);
    applyStimulus(32'h0020A463, 1'b0, 1'b0, 1'b0);
    checkOutput("illbr state", {29'd0, state}, 5);
    checkOutput("illbr illegal", {31'd0, illegal}, 1);
    doReset();

    // Fetch timeout after exactly 15 request cycles
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0);
      if (state !== 3'd0) checkOutput($sformatf("to fetch%0d state", k), {29'd0, state}, 0);
      nextCycle();
    end
    checkOutput("to state", {29'd0, state}, 5);
    checkOutput("to timeout", {31'd0, timeout}, 1);
    checkOutput("to imem_req", {31'd0, imem_req}, 0);
    doReset();
    checkOutput("to reset timeout", {31'd0, timeout}, 0);

    // Ready in the 15th cycle wins over the timeout
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(32'h002081B3, (k == 15), 1'b0, 1'b0);
      if (state !== 3'd0) checkOutput($sformatf("late fetch%0d state", k), {29'd0, state}, 0);
      nextCycle();
    end
    checkOutput("late state", {29'd0, state}, 1);
    checkOutput("late timeout", {31'd0, timeout}, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV64 base core.
- Sequences fetch, decode, execute, memory and writeback for the four supported instruction classes: R-type (0110011), load (0000011), store (0100011) and branch (1100011).
- Drives the IR/PC write enables, the ALU operand and op selects, the memory request strobes and register writeback.
- Sits beside the immediate generator, register file and ALU. The 64-bit immediate consumed under its alu_src_b/pc_src selects comes from the immediate generator.

Parameters:
- WAIT_MAX, 15: maximum consecutive memory-request cycles without ready before fault. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- instr  input  32  current IR contents; valid from DECODE onward
- zero  input  1  ALU zero flag; combinational in EXEC
- imem_ready  input  1  instruction memory data valid
- dmem_ready  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (store)
- ir_we  output  1  instruction register load
- pc_we  output  1  PC update
- pc_src  output  1  0: PC+4, 1: PC+imm
- alu_src_b  output  1  0: rs2, 1: imm
- alu_op  output  2  00 add, 01 sub, 10 decode funct3/funct7, 11 unused
- reg_we  output  1  register file write
- wb_sel  output  1  0: ALU result, 1: load data
- state  output  3  current state encoding (debug)
- illegal  output  1  sticky: unsupported opcode/funct3 decoded
- timeout  output  1  sticky: memory wait exceeded WAIT_MAX

Behaviour:
- Clocking and reset:
  - Single clock. All flops update on rising clk.
  - rst_n=0 at an edge: state=FETCH, class register=R, wait_cnt=0, illegal=0, timeout=0.
  - Reset mid-operation abandons the instruction. All strobes follow the reset state from the next cycle.
- Output timing:
  - All outputs are combinational from registered state, the latched class, instr and the ready/zero inputs.
  - Every strobe not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - imem_req=1.
  - imem_ready=1 → ir_we=1 this cycle, next state DECODE.
- DECODE:
  - Latch class from instr[6:0].
  - Branch with funct3 not 000 (BEQ) or 001 (BNE) is illegal.
  - Unsupported opcode or illegal branch → illegal=1, next HALT.
  - Otherwise next EXEC.
- EXEC, by class:
  - R: alu_src_b=0, alu_op=10, next WB.
  - Load/store: alu_src_b=1, alu_op=00, next MEM.
  - Branch: alu_src_b=0, alu_op=01, pc_we=1, pc_src=taken, next FETCH. taken = zero for BEQ, !zero for BNE.
- MEM:
  - dmem_req=1, dmem_we=1 for store.
  - On dmem_ready, load: next WB.
  - On dmem_ready, store: pc_we=1, pc_src=0, next FETCH.
- WB:
  - reg_we=1 unless rd (instr[11:7]) == 0; then reg_we=0.
  - wb_sel=1 for load, 0 for R.
  - pc_we=1, pc_src=0, next FETCH.
- HALT:
  - All strobes 0. Remains in HALT until reset.
  - illegal/timeout hold their values.
- Wait counter (8-bit):
  - Clears on every state change.
  - Increments each FETCH/MEM cycle with ready=0.
  - If ready=0 in the WAIT_MAX-th consecutive request cycle → timeout=1, next HALT.
  - Ready arriving in that same cycle wins: normal transition, no timeout.
- Latency with zero memory wait:
  - R = 4 cycles, load = 5, store = 4, branch = 3.
- Ready asserted outside FETCH/MEM is ignored.
- ir_we is never asserted outside FETCH.

Test Plan:
1. Reset, then R-type 0x002081B3 (add x3,x1,x2) with imem_ready=1 → states 0,1,2,4,0. ir_we in cycle 1. alu_op=10 in EXEC. reg_we=1, wb_sel=0, pc_we=1 in WB.
2. Load 0x0080B183 with dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1, dmem_we=0. WB has reg_we=1, wb_sel=1. timeout stays 0.
3. BEQ 0x00208463: zero=1 → EXEC pc_we=1, pc_src=1. Repeat with zero=0 → pc_src=0. BNE (funct3=001) with zero=0 → pc_src=1.
4. Opcode 0x0000007F → illegal=1, state=5 after DECODE. No further imem_req until rst_n=0 for one edge, then FETCH, illegal=0.
5. WAIT_MAX=15, imem_ready held 0 → timeout=1, state=5 after exactly 15 FETCH cycles. Separately, ready on cycle 15 → DECODE, no timeout.
6. R-type with rd=0 (0x00208033) → WB reg_we=0, pc_we=1. rst_n=0 during MEM of a store → dmem_req=0 next cycle, state=0.
